// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush scheduler.
// Stage vectors are indexed IF (bit 0) through WB (bit 4).
package pipe_ctrl_pkg;

    localparam int STG_N   = 5;
    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    typedef logic [STG_N-1:0] stage_vec_t;

    typedef logic [1:0] pipe_state_t;
    localparam pipe_state_t RUN       = 2'd0;
    localparam pipe_state_t DIV_WAIT  = 2'd1;
    localparam pipe_state_t EXC_FLUSH = 2'd2;

    localparam stage_vec_t STG_NONE    = '0;
    localparam stage_vec_t STALL_HAZ   = stage_vec_t'((1 << STG_IF) | (1 << STG_ID));
    localparam stage_vec_t STALL_DIV   = STALL_HAZ | stage_vec_t'(1 << STG_EX);
    localparam stage_vec_t STALL_MEM   = STALL_DIV | stage_vec_t'(1 << STG_MEM);
    localparam stage_vec_t FLUSH_HAZ   = stage_vec_t'(1 << STG_EX);
    localparam stage_vec_t FLUSH_DIV   = stage_vec_t'(1 << STG_MEM);
    localparam stage_vec_t FLUSH_WB    = stage_vec_t'(1 << STG_WB);
    localparam stage_vec_t FLUSH_EXC   = STALL_MEM;
    localparam stage_vec_t FLUSH_REDIR = STALL_HAZ;

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    function automatic logic load_use(input logic rmem, input logic [4:0] waddr,
                                      input logic [4:0] rs, input logic [4:0] rt);
        return rmem && (waddr != 5'd0) && ((waddr == rs) || (waddr == rt));
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and stall/flush/redirect outputs between the pipeline and pipe_ctrl.
// The slave side is the scheduler; the master side is the pipeline datapath.
interface pipe_ctrl_if #(parameter int PERF_W = 32);
    import pipe_ctrl_pkg::*;

    logic              id_branch_stall_i;
    logic [4:0]        id_rs_i;
    logic [4:0]        id_rt_i;
    logic              ex_rmem_i;
    logic [4:0]        ex_waddr_i;
    logic              ex_div_i;
    logic              div_ready_i;
    logic              imem_stall_i;
    logic              dmem_stall_i;
    logic              mem_excpt_i;
    logic [31:0]       mem_excpt_pc_i;
    stage_vec_t        stall_o;
    stage_vec_t        flush_o;
    logic              redirect_o;
    logic [31:0]       redirect_pc_o;
    logic              div_start_o;
    logic              div_cancel_o;
    logic              div_err_o;
    logic [PERF_W-1:0] perf_stall_o;

    modport slave (
        input  id_branch_stall_i, id_rs_i, id_rt_i, ex_rmem_i, ex_waddr_i, ex_div_i,
               div_ready_i, imem_stall_i, dmem_stall_i, mem_excpt_i, mem_excpt_pc_i,
        output stall_o, flush_o, redirect_o, redirect_pc_o, div_start_o, div_cancel_o,
               div_err_o, perf_stall_o
    );

    modport master (
        output id_branch_stall_i, id_rs_i, id_rt_i, ex_rmem_i, ex_waddr_i, ex_div_i,
               div_ready_i, imem_stall_i, dmem_stall_i, mem_excpt_i, mem_excpt_pc_i,
        input  stall_o, flush_o, redirect_o, redirect_pc_o, div_start_o, div_cancel_o,
               div_err_o, perf_stall_o
    );

endinterface

// File: rtl/pipe_div_watchdog.sv
// Divider watchdog: counts DIV_WAIT cycles, flags a timeout on the DIV_MAX-th
// waiting cycle and keeps a sticky error that only reset clears.
module pipe_div_watchdog #(
    parameter int DIV_MAX = 40
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic active,
    input  logic ready,
    input  logic abort,
    output logic timeout,
    output logic err
);
    localparam int CNT_W = $clog2(DIV_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_MAX - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    // A ready or an exception in the expiry cycle wins over the timeout.
    assign timeout = active && (cnt_q == CNT_LAST) && !ready && !abort;
    assign err     = err_q | timeout;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (clear)
                cnt_q <= '0;
            else if (active && cnt_q != CNT_LAST)
                cnt_q <= cnt_q + 1'b1;
            if (timeout)
                err_q <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush scheduler for the five-stage pipeline: prioritises
// exceptions, bus waits, divider and decode hazards into stage enables/clears.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int PERF_W  = 32,
    parameter int DIV_MAX = 40
) (
    input  logic        clk_i,
    input  logic        rst_i,
    pipe_ctrl_if.slave  bus
);
    pipe_state_t       state_q, state_d;
    stage_vec_t        stall, flush;
    logic              div_start, div_cancel, excpt_take;
    logic              wd_timeout, wd_err;
    logic              redirect_q;
    logic [31:0]       redirect_pc_q;
    logic [PERF_W-1:0] perf_q;
    logic              hazard;

    assign hazard = load_use(bus.ex_rmem_i, bus.ex_waddr_i, bus.id_rs_i, bus.id_rt_i)
                  || bus.id_branch_stall_i || bus.imem_stall_i;

    pipe_div_watchdog #(.DIV_MAX(DIV_MAX)) u_watchdog (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (div_start),
        .active  (state_q == DIV_WAIT),
        .ready   (bus.div_ready_i),
        .abort   (bus.mem_excpt_i),
        .timeout (wd_timeout),
        .err     (wd_err)
    );

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        stall      = STG_NONE;
        flush      = STG_NONE;
        div_start  = 1'b0;
        div_cancel = 1'b0;
        excpt_take = 1'b0;
        state_d    = state_q;
        // Outputs stay quiet while reset is held, even with hazards pending.
        if (rst_i) begin
            case (state_q)
                RUN: begin
                    if (bus.mem_excpt_i) begin
                        flush      = FLUSH_EXC;
                        excpt_take = 1'b1;
                        state_d    = EXC_FLUSH;
                    end else if (bus.dmem_stall_i) begin
                        stall = STALL_MEM;
                        flush = FLUSH_WB;
                    end else if (bus.ex_div_i) begin
                        div_start = 1'b1;
                        stall     = STALL_DIV;
                        flush     = FLUSH_DIV;
                        state_d   = DIV_WAIT;
                    end else if (hazard) begin
                        stall = STALL_HAZ;
                        flush = FLUSH_HAZ;
                    end
                end
                DIV_WAIT: begin
                    if (bus.mem_excpt_i) begin
                        div_cancel = 1'b1;
                        flush      = FLUSH_EXC;
                        excpt_take = 1'b1;
                        state_d    = EXC_FLUSH;
                    end else begin
                        if (bus.dmem_stall_i) begin
                            stall = STALL_MEM;
                            flush = FLUSH_WB;
                        end else if (!(bus.div_ready_i || wd_timeout)) begin
                            stall = STALL_DIV;
                            flush = FLUSH_DIV;
                        end
                        if (bus.div_ready_i || wd_timeout)
                            state_d = RUN;
                        div_cancel = wd_timeout;
                    end
                end
                EXC_FLUSH: begin
                    flush   = FLUSH_REDIR;
                    state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= RUN;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            perf_q        <= '0;
        end else begin
            state_q    <= state_d;
            redirect_q <= excpt_take;
            if (excpt_take)
                redirect_pc_q <= bus.mem_excpt_pc_i;
            if (|stall && !(&perf_q))
                perf_q <= perf_q + 1'b1;
        end
    end

    assign bus.stall_o       = stall;
    assign bus.flush_o       = flush;
    assign bus.div_start_o   = div_start;
    assign bus.div_cancel_o  = div_cancel;
    assign bus.div_err_o     = wd_err;
    assign bus.redirect_o    = redirect_q;
    assign bus.redirect_pc_o = redirect_pc_q;
    assign bus.perf_stall_o  = perf_q;

endmodule
